// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop synchronizer feeding a four-state qualify FSM with a stability down-counter.
// Optional DB_PRESCALE_EN: count steps advance only on a free-running prescaler tick instead of every clock.
module switch_debouncer #(
    parameter int CNT_W        = 20,
    parameter int STABLE_COUNT = 1000000,
    parameter int PRESCALE     = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db,
    output logic busy
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(STABLE_COUNT - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("switch_debouncer: PRESCALE must be at least 1");
    end
    if (STABLE_COUNT < 1 || longint'(STABLE_COUNT) > (longint'(1) << CNT_W)) begin : g_bad_count
        $error("switch_debouncer: STABLE_COUNT out of range for CNT_W");
    end

    logic             sync_0;
    logic             sync_1;
    logic             step;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= sw;
            sync_1 <= sync_0;
        end
    end

`ifdef DB_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale;

    // Free-running; never restarted on WAIT entry, so the first step after entry jitters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (prescale == PS_LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PS_W'(1);
        end
    end

    assign step = (prescale == PS_LAST);
`else
    assign step = 1'b1;
`endif

    // Level check wins over the counter: a bounce on the final count step aborts rather than commits.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            ZERO: begin
                if (sync_1) begin
                    next_state = WAIT1;
                    next_count = LOAD;
                end
            end
            WAIT1: begin
                if (!sync_1) begin
                    next_state = ZERO;
                end else if (step) begin
                    if (count == '0) begin
                        next_state = ONE;
                    end else begin
                        next_count = count - CNT_W'(1);
                    end
                end
            end
            ONE: begin
                if (!sync_1) begin
                    next_state = WAIT0;
                    next_count = LOAD;
                end
            end
            WAIT0: begin
                if (sync_1) begin
                    next_state = ONE;
                end else if (step) begin
                    if (count == '0) begin
                        next_state = ZERO;
                    end else begin
                        next_count = count - CNT_W'(1);
                    end
                end
            end
            default: begin
                next_state = ZERO;
            end
        endcase
    end

    // Outputs are flopped decodes of the state register, keeping sw fully isolated from db/busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
            count <= '0;
            db    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            db    <= (state == ONE) || (state == WAIT0);
            busy  <= (state == WAIT1) || (state == WAIT0);
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: constant vector table, hand-built corner sequences,
// and random switch activity compared against a sliding-window reference model.
module tb_switch_debouncer;

    localparam int CNT_W = 20;
`ifdef DB_PRESCALE_EN
    localparam int SC = 2;
`else
    localparam int SC = 4;
`endif
    localparam int PS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sw    = 1'b0;
    logic db;
    logic busy;
    logic db_one;
    logic busy_one;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic sw;
        logic db;
        logic busy;
    } vec_t;

    vec_t vecs[20];

    logic hist[$];
    logic model_db;
    logic model_busy;
    logic model_db_one;
    logic model_busy_one;

    always #5 clk = ~clk;

    switch_debouncer #(.CNT_W(CNT_W), .STABLE_COUNT(SC), .PRESCALE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db),
        .busy  (busy)
    );

    switch_debouncer #(.CNT_W(CNT_W), .STABLE_COUNT(1), .PRESCALE(PS)) dut_one (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db_one),
        .busy  (busy_one)
    );

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual >= lo && actual <= hi) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    function automatic logic sample_at(input int idx);
        if (idx < 0 || idx >= hist.size()) begin
            return 1'b0;
        end
        return hist[idx];
    endfunction

    // db flips once the last sc+1 synchronized samples (3-edge pipeline) all disagree with it.
    function automatic logic next_level(input int n, input int sc, input logic level);
        for (int i = n - 3 - sc; i <= n - 3; i++) begin
            if (sample_at(i) == level) begin
                return level;
            end
        end
        return ~level;
    endfunction

    // Drive one sample at the negedge; the following posedge is the edge it enters sync_0.
    task automatic apply_stimulus(input logic value, input bit chk, input string name);
        int n;
        sw = value;
        @(posedge clk);
        hist.push_back(value);
        n = hist.size() - 1;
        model_db       = next_level(n, SC, model_db);
        model_busy     = (sample_at(n - 3) != model_db);
        model_db_one   = next_level(n, 1, model_db_one);
        model_busy_one = (sample_at(n - 3) != model_db_one);
        @(negedge clk);
        if (chk) begin
            check_output({name, "_db"}, db, model_db);
            check_output({name, "_busy"}, busy, model_busy);
            check_output({name, "_db_sc1"}, db_one, model_db_one);
            check_output({name, "_busy_sc1"}, busy_one, model_busy_one);
        end
    endtask

    task automatic do_reset(input logic level);
        @(negedge clk);
        reset = 1'b1;
        sw    = level;
        repeat (2) @(negedge clk);
        reset          = 1'b0;
        hist.delete();
        model_db       = 1'b0;
        model_busy     = 1'b0;
        model_db_one   = 1'b0;
        model_busy_one = 1'b0;
    endtask

    initial begin
        int rose_at;
        int len;
        logic lvl;
        bit done;

        vecs = '{
            '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}
        };

        do_reset(1'b0);
        check_output("reset_db", db, 1'b0);
        check_output("reset_busy", busy, 1'b0);

`ifdef DB_PRESCALE_EN
        repeat (10) apply_stimulus(1'b0, 1'b0, "idle");
        rose_at = -1;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 1'b0, "ps_rise");
            if (db === 1'b1 && rose_at < 0) rose_at = k;
        end
        check_range("ps_rise_latency", rose_at, 7, 9);

        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            apply_stimulus(1'b0, 1'b0, "ps_fall");
            if (db === 1'b0) done = 1'b1;
        end
        check_output("ps_fall_done", db, 1'b0);
        repeat (10) apply_stimulus(1'b0, 1'b0, "idle");

        rose_at = -1;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus((k == 2) ? 1'b0 : 1'b1, 1'b0, "ps_bounce");
            if (db === 1'b1 && rose_at < 0) rose_at = k;
        end
        check_range("ps_bounce_latency", rose_at, 10, 12);
`else
        for (int k = 0; k < 20; k++) apply_stimulus(1'b0, 1'b1, "idle");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sw, 1'b1, "table_model");
            check_output($sformatf("table%0d_db", i), db, vecs[i].db);
            check_output($sformatf("table%0d_busy", i), busy, vecs[i].busy);
        end

        repeat (10) apply_stimulus(1'b0, 1'b1, "idle");
        for (int j = 0; j < 14; j++) begin
            apply_stimulus((j == 3) ? 1'b0 : 1'b1, 1'b1, "bounce");
            check_output($sformatf("bounce%0d_db", j), db, (j >= 11) ? 1'b1 : 1'b0);
            if (j == 6) check_output("bounce_abort_busy", busy, 1'b0);
        end

        for (int j = 0; j < 4; j++) apply_stimulus(1'b0, 1'b1, "wait0");
        check_output("wait0_db", db, 1'b1);
        check_output("wait0_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_output("async_reset_db", db, 1'b0);
        check_output("async_reset_busy", busy, 1'b0);
        do_reset(1'b0);
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b0, 1'b1, "post_reset");
            check_output("post_reset_db", db, 1'b0);
        end

        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 1'b1, "held_high");
            check_output($sformatf("held_high%0d_db", k), db, (k >= SC + 3) ? 1'b1 : 1'b0);
        end

        do_reset(1'b0);
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            len = $urandom_range(1, 8);
            lvl = ~lvl;
            for (int r = 0; r < len; r++) apply_stimulus(lvl, 1'b1, "random");
        end
`endif

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
